pc_file_ctrl: RTL and testbench
===============================

Name: pc_file_ctrl

Overview:
Allocation and write-port controller for the 32-entry PC file. It hands out PC-file indices in program order as a circular buffer and frees them in order at commit. It rewinds the allocation pointer on a pipeline flush. It also arbitrates the PC file's single write port between new allocations (fetch) and PC patches to live entries (branch resolution).

Parameters:
WORD_SIZE, 31, width of one stored PC word (PC[31:1]).
ADDR_SIZE, 5, index width; the buffer has 2^ADDR_SIZE entries.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
alloc_valid  in  1  fetch requests a new entry
alloc_pc  in  WORD_SIZE  PC to store in the new entry
alloc_ready  out  1  allocation accepted this cycle when alloc_valid=1
alloc_idx  out  ADDR_SIZE  index assigned to the allocation (current head)
patch_valid  in  1  overwrite the PC of an existing entry
patch_idx  in  ADDR_SIZE  entry to overwrite
patch_pc  in  WORD_SIZE  new PC value
free_valid  in  1  commit frees the oldest live entry
flush_valid  in  1  discard younger entries
flush_all  in  1  with flush_valid: discard every live entry
flush_idx  in  ADDR_SIZE  youngest surviving entry (ignored if flush_all)
tail_idx  out  ADDR_SIZE  oldest live entry
count  out  ADDR_SIZE+1  number of live entries
full  out  1  count == 2^ADDR_SIZE
empty  out  1  count == 0
wen0  out  1  PC file write enable (registered)
waddr0  out  ADDR_SIZE  PC file write address (registered)
wdata0  out  WORD_SIZE  PC file write data (registered)

Behaviour:
- State: head and tail pointers (ADDR_SIZE bits, wrap mod 2^ADDR_SIZE), a count register, and the write-port register.
- Reset (rst=0 at a clk edge):
  - head, tail and count go to 0.
  - wen0, waddr0 and wdata0 go to 0.
  - empty=1, full=0, alloc_idx=0, tail_idx=0.
  - Reset mid-operation discards all state, including a pending write.
- alloc_ready = !full && !patch_valid && !flush_valid. It is combinational.
  - A same-cycle free does not make room.
  - alloc_ready does not depend on alloc_valid.
- alloc_fire = alloc_valid && alloc_ready.
  - Next cycle: head+1, and wen0=1, waddr0=alloc_idx, wdata0=alloc_pc.
- Write-port priority: patch > alloc.
  - patch_fire = patch_valid && !flush_valid.
  - Next cycle: wen0=1, waddr0=patch_idx, wdata0=patch_pc. Alloc stalls that cycle.
  - Patching a non-live index is legal: it is written, with no state change.
- Write latency: the PC file content is readable 2 cycles after alloc_fire or patch_fire (register stage plus the PC file's write edge).
- Free: when free_valid=1, tail advances by 1.
  - Free with empty=1 is illegal and is ignored: tail and count hold.
- Count update without flush: count + alloc_fire - free_valid.
  - Alloc and free in the same cycle when full cannot occur, because alloc_ready=0.
- Flush (flush_valid=1) overrides alloc and patch; neither fires.
  - flush_all=1: head <= tail_next, count <= 0. tail_next = tail + free_valid.
  - flush_all=0: head <= flush_idx+1, count <= ((flush_idx - tail) mod 2^ADDR_SIZE) + 1 - free_valid.
  - flush_idx must be live. If free_valid=1 in the same cycle, flush_idx must not equal tail.
  - A write registered on the previous cycle still completes, even if it targets a flushed index.
- wen0 is 0 in any cycle following a cycle with no fire. waddr0 and wdata0 hold their last values.
- Wrap-around:
  - head and tail wrap 31 -> 0.
  - count distinguishes full (32) from empty (0).

Decomposition:
- Shared package: PC word width, PC-file index width and entry count, typedef for an index, typedef for a write-port bundle {wen, addr, data}.
- One sub-module is natural: pc_ring_ptr. It holds the head/tail/count pointer logic with alloc/free/rewind inputs.
- The write-port arbiter and register stay in pc_file_ctrl.

Test Plan:
- Reset, then alloc_valid=1 with alloc_pc=0x00001000 -> alloc_ready=1, alloc_idx=0. Next cycle: wen0=1, waddr0=0, wdata0=0x00001000, count=1.
- 32 back-to-back allocs -> full=1, alloc_ready=0, alloc_idx=0. One free -> tail_idx=1, count=31, then alloc_idx=0 is accepted (wrap).
- alloc_valid and patch_valid (idx=3, pc=0x7FFF0000) in the same cycle -> alloc_ready=0. Next cycle: waddr0=3, wdata0=0x7FFF0000; alloc accepted the cycle after.
- Entries 0..9 live. flush_valid with flush_idx=4 -> head=5, count=5, and the next alloc_idx=5. A same-cycle patch is dropped (wen0=0 next cycle).
- Entries 30,31,0,1 live (tail=30). flush_all together with free_valid -> count=0, empty=1, tail_idx=31, alloc_idx=31.
- Pulse rst=0 one cycle after an alloc fires -> wen0=0, count=0, head=tail=0 on the following cycle.

Source files
------------

// File: rtl/pc_file_ctrl_pkg.sv
// Shared widths and types for the PC-file allocation controller.
package pc_file_ctrl_pkg;

  localparam int PC_W    = 31;
  localparam int IDX_W   = 5;
  localparam int ENTRIES = 1 << IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PC_W-1:0]  pc_word_t;

  typedef struct packed {
    logic     wen;
    idx_t     addr;
    pc_word_t data;
  } wport_t;

endpackage

// File: rtl/pc_file_ctrl_ring_ptr.sv
// Head/tail/count bookkeeping for the circular PC-file index allocator.
module pc_ring_ptr
  import pc_file_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc,
  input  logic                 free,
  input  logic                 rewind,
  input  logic                 rewind_all,
  input  logic [ADDR_SIZE-1:0] rewind_idx,
  output logic [ADDR_SIZE-1:0] head,
  output logic [ADDR_SIZE-1:0] tail,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [ADDR_SIZE:0] DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};

  logic                 free_ok;
  logic [ADDR_SIZE-1:0] tail_next;
  logic [ADDR_SIZE-1:0] span;
  logic [ADDR_SIZE:0]   kept;

  assign empty = (count == '0);
  assign full  = (count == DEPTH);

  // A free on an empty ring is dropped so tail never overtakes head.
  assign free_ok   = free && !empty;
  assign tail_next = tail + ADDR_SIZE'(free_ok);
  assign span      = rewind_idx - tail;
  assign kept      = {1'b0, span} + (ADDR_SIZE+1)'(1) - (ADDR_SIZE+1)'(free_ok);

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail <= tail_next;
      if (rewind) begin
        if (rewind_all) begin
          head  <= tail_next;
          count <= '0;
        end else begin
          head  <= rewind_idx + ADDR_SIZE'(1);
          count <= kept;
        end
      end else begin
        head  <= head + ADDR_SIZE'(alloc);
        count <= count + (ADDR_SIZE+1)'(alloc) - (ADDR_SIZE+1)'(free_ok);
      end
    end
  end

endmodule

// File: rtl/pc_file_ctrl.sv
// PC-file index allocator with flush rewind and a registered, patch-priority write port.
module pc_file_ctrl
  import pc_file_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = PC_W,
  parameter int ADDR_SIZE = IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic [WORD_SIZE-1:0] alloc_pc,
  output logic                 alloc_ready,
  output logic [ADDR_SIZE-1:0] alloc_idx,
  input  logic                 patch_valid,
  input  logic [ADDR_SIZE-1:0] patch_idx,
  input  logic [WORD_SIZE-1:0] patch_pc,
  input  logic                 free_valid,
  input  logic                 flush_valid,
  input  logic                 flush_all,
  input  logic [ADDR_SIZE-1:0] flush_idx,
  output logic [ADDR_SIZE-1:0] tail_idx,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 wen0,
  output logic [ADDR_SIZE-1:0] waddr0,
  output logic [WORD_SIZE-1:0] wdata0
);

  logic                 alloc_fire;
  logic                 patch_fire;
  logic [ADDR_SIZE-1:0] head;
  wport_t               wport_p1;

  // Patches and flushes own the cycle; a same-cycle free never makes room.
  assign alloc_ready = !full && !patch_valid && !flush_valid;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign patch_fire  = patch_valid && !flush_valid;
  assign alloc_idx   = head;

  pc_ring_ptr #(
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .alloc      (alloc_fire),
    .free       (free_valid),
    .rewind     (flush_valid),
    .rewind_all (flush_all),
    .rewind_idx (flush_idx),
    .head       (head),
    .tail       (tail_idx),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // Stage p1: write-port register feeding the PC file
  always_ff @(posedge clk) begin
    if (!rst) begin
      wport_p1 <= '0;
    end else if (patch_fire) begin
      wport_p1 <= '{wen: 1'b1, addr: patch_idx, data: patch_pc};
    end else if (alloc_fire) begin
      wport_p1 <= '{wen: 1'b1, addr: head, data: alloc_pc};
    end else begin
      wport_p1.wen <= 1'b0;
    end
  end

  assign wen0   = wport_p1.wen;
  assign waddr0 = wport_p1.addr;
  assign wdata0 = wport_p1.data;

endmodule

// File: tb/tb_pc_file_ctrl.sv
// Self-checking bench for pc_file_ctrl: vector table, directed corner sequences, random vs. queue model.
module tb_pc_file_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [30:0] alloc_pc;
  logic        alloc_ready;
  logic [4:0]  alloc_idx;
  logic        patch_valid;
  logic [4:0]  patch_idx;
  logic [30:0] patch_pc;
  logic        free_valid;
  logic        flush_valid;
  logic        flush_all;
  logic [4:0]  flush_idx;
  logic [4:0]  tail_idx;
  logic [5:0]  count;
  logic        full;
  logic        empty;
  logic        wen0;
  logic [4:0]  waddr0;
  logic [30:0] wdata0;

  int errors = 0;
  int checks = 0;
  bit mchk   = 1'b0;

  // Reference model: live indices in program order plus the next index to hand out.
  int          live[$];
  int          nxt     = 0;
  bit          mw_en   = 1'b0;
  int          mw_addr = 0;
  logic [30:0] mw_data = '0;

  typedef struct {
    bit          r;
    bit          av;
    logic [30:0] apc;
    bit          pv;
    logic [4:0]  pidx;
    logic [30:0] ppc;
    bit          fv;
    bit          flv;
    bit          fall;
    logic [4:0]  fidx;
    bit          e_rdy;
    logic [4:0]  e_aidx;
    logic [5:0]  e_cnt;
    bit          e_wen;
    logic [4:0]  e_waddr;
    logic [30:0] e_wdata;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  pc_file_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_pc    (alloc_pc),
    .alloc_ready (alloc_ready),
    .alloc_idx   (alloc_idx),
    .patch_valid (patch_valid),
    .patch_idx   (patch_idx),
    .patch_pc    (patch_pc),
    .free_valid  (free_valid),
    .flush_valid (flush_valid),
    .flush_all   (flush_all),
    .flush_idx   (flush_idx),
    .tail_idx    (tail_idx),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .wen0        (wen0),
    .waddr0      (waddr0),
    .wdata0      (wdata0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_tail();
    return (live.size() != 0) ? live[0] : nxt;
  endfunction

  task automatic model_check();
    chk("alloc_ready", 32'(alloc_ready), 32'(live.size() < 32 && !patch_valid && !flush_valid));
    chk("alloc_idx", 32'(alloc_idx), nxt);
    chk("tail_idx", 32'(tail_idx), m_tail());
    chk("count", 32'(count), live.size());
    chk("full", 32'(full), 32'(live.size() == 32));
    chk("empty", 32'(empty), 32'(live.size() == 0));
    chk("wen0", 32'(wen0), 32'(mw_en));
    chk("waddr0", 32'(waddr0), mw_addr);
    chk("wdata0", 32'(wdata0), 32'(mw_data));
  endtask

  task automatic model_update();
    bit afire;
    int tn;
    if (!rst) begin
      live.delete();
      nxt     = 0;
      mw_en   = 1'b0;
      mw_addr = 0;
      mw_data = '0;
      return;
    end
    afire = alloc_valid && live.size() < 32 && !patch_valid && !flush_valid;
    if (patch_valid && !flush_valid) begin
      mw_en = 1'b1; mw_addr = int'(patch_idx); mw_data = patch_pc;
    end else if (afire) begin
      mw_en = 1'b1; mw_addr = nxt; mw_data = alloc_pc;
    end else begin
      mw_en = 1'b0;
    end
    if (free_valid && live.size() != 0) void'(live.pop_front());
    if (flush_valid) begin
      if (flush_all) begin
        tn = m_tail();
        live.delete();
        nxt = tn;
      end else begin
        while (live.size() != 0 && live[$] != int'(flush_idx)) void'(live.pop_back());
        nxt = (int'(flush_idx) + 1) % 32;
      end
    end else if (afire) begin
      live.push_back(nxt);
      nxt = (nxt + 1) % 32;
    end
  endtask

  task automatic finish_cycle();
    if (mchk) model_check();
    model_update();
    @(posedge clk);
    #1;
    rst = 1'b1; alloc_valid = 1'b0; patch_valid = 1'b0;
    free_valid = 1'b0; flush_valid = 1'b0; flush_all = 1'b0;
  endtask

  task automatic apply(input bit r, input bit av, input logic [30:0] apc, input bit pv,
                       input logic [4:0] pidx, input logic [30:0] ppc, input bit fv,
                       input bit flv, input bit fall, input logic [4:0] fidx);
    rst = r; alloc_valid = av; alloc_pc = apc; patch_valid = pv; patch_idx = pidx;
    patch_pc = ppc; free_valid = fv; flush_valid = flv; flush_all = fall; flush_idx = fidx;
    #2;
    finish_cycle();
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_alloc(input logic [30:0] pc);
    apply(1'b1, 1'b1, pc, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_free();
    apply(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // r av apc pv pidx ppc fv flv fall fidx | rdy aidx cnt wen waddr wdata
    tbl[0] = '{1'b1, 1'b1, 31'h1000, 1'b0, 5'd0, 31'h0, 1'b0, 1'b0, 1'b0, 5'd0,
               1'b1, 5'd0, 6'd0, 1'b0, 5'd0, 31'h0};
    tbl[1] = '{1'b1, 1'b1, 31'h2000, 1'b1, 5'd3, 31'h7FFF0000, 1'b0, 1'b0, 1'b0, 5'd0,
               1'b0, 5'd1, 6'd1, 1'b1, 5'd0, 31'h1000};
    tbl[2] = '{1'b1, 1'b1, 31'h2000, 1'b0, 5'd0, 31'h0, 1'b0, 1'b0, 1'b0, 5'd0,
               1'b1, 5'd1, 6'd1, 1'b1, 5'd3, 31'h7FFF0000};
    tbl[3] = '{1'b1, 1'b0, 31'h0, 1'b0, 5'd0, 31'h0, 1'b0, 1'b0, 1'b0, 5'd0,
               1'b1, 5'd2, 6'd2, 1'b1, 5'd1, 31'h2000};
    tbl[4] = '{1'b1, 1'b0, 31'h0, 1'b0, 5'd0, 31'h0, 1'b1, 1'b0, 1'b0, 5'd0,
               1'b1, 5'd2, 6'd2, 1'b0, 5'd1, 31'h2000};
    tbl[5] = '{1'b1, 1'b0, 31'h0, 1'b0, 5'd0, 31'h0, 1'b1, 1'b0, 1'b0, 5'd0,
               1'b1, 5'd2, 6'd1, 1'b0, 5'd1, 31'h2000};
    tbl[6] = '{1'b1, 1'b0, 31'h0, 1'b0, 5'd0, 31'h0, 1'b1, 1'b0, 1'b0, 5'd0,
               1'b1, 5'd2, 6'd0, 1'b0, 5'd1, 31'h2000};
    tbl[7] = '{1'b1, 1'b0, 31'h0, 1'b0, 5'd0, 31'h0, 1'b0, 1'b0, 1'b0, 5'd0,
               1'b1, 5'd2, 6'd0, 1'b0, 5'd1, 31'h2000};

    rst = 1'b0; alloc_valid = 1'b0; alloc_pc = '0; patch_valid = 1'b0; patch_idx = '0;
    patch_pc = '0; free_valid = 1'b0; flush_valid = 1'b0; flush_all = 1'b0; flush_idx = '0;
    do_reset();
    do_reset();
    mchk = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].r; alloc_valid = tbl[i].av; alloc_pc = tbl[i].apc;
      patch_valid = tbl[i].pv; patch_idx = tbl[i].pidx; patch_pc = tbl[i].ppc;
      free_valid = tbl[i].fv; flush_valid = tbl[i].flv; flush_all = tbl[i].fall;
      flush_idx = tbl[i].fidx;
      #2;
      chk($sformatf("tbl%0d.alloc_ready", i), 32'(alloc_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.alloc_idx", i), 32'(alloc_idx), 32'(tbl[i].e_aidx));
      chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.wen0", i), 32'(wen0), 32'(tbl[i].e_wen));
      chk($sformatf("tbl%0d.waddr0", i), 32'(waddr0), 32'(tbl[i].e_waddr));
      chk($sformatf("tbl%0d.wdata0", i), 32'(wdata0), 32'(tbl[i].e_wdata));
      finish_cycle();
    end

    // Fill to full, free one, wrap the next allocation back to index 0
    do_reset();
    for (int i = 0; i < 32; i++) do_alloc(31'(i * 4 + 1));
    chk("full.full", 32'(full), 32'd1);
    chk("full.alloc_ready", 32'(alloc_ready), 32'd0);
    chk("full.alloc_idx", 32'(alloc_idx), 32'd0);
    chk("full.count", 32'(count), 32'd32);
    do_free();
    chk("wrap.tail_idx", 32'(tail_idx), 32'd1);
    chk("wrap.count", 32'(count), 32'd31);
    chk("wrap.alloc_ready", 32'(alloc_ready), 32'd1);
    do_alloc(31'h55);
    chk("wrap.waddr0", 32'(waddr0), 32'd0);
    chk("wrap.wdata0", 32'(wdata0), 32'h55);
    chk("wrap.count2", 32'(count), 32'd32);

    // Partial flush drops a same-cycle patch and alloc
    do_reset();
    for (int i = 0; i < 10; i++) do_alloc(31'(100 + i));
    apply(1'b1, 1'b1, 31'h999, 1'b1, 5'd7, 31'h1234, 1'b0, 1'b1, 1'b0, 5'd4);
    chk("flush.wen0", 32'(wen0), 32'd0);
    chk("flush.count", 32'(count), 32'd5);
    chk("flush.alloc_idx", 32'(alloc_idx), 32'd5);
    chk("flush.tail_idx", 32'(tail_idx), 32'd0);
    do_alloc(31'h777);
    chk("flush.next_waddr0", 32'(waddr0), 32'd5);
    chk("flush.next_wdata0", 32'(wdata0), 32'h777);

    // Flush-all with a same-cycle free across the 31 -> 0 wrap
    do_reset();
    for (int i = 0; i < 30; i++) apply(1'b1, 1'b1, 31'(i), 1'b0, '0, '0, bit'(i > 0), 1'b0, 1'b0, '0);
    do_free();
    chk("fall.pre_tail", 32'(tail_idx), 32'd30);
    chk("fall.pre_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 4; i++) do_alloc(31'(200 + i));
    chk("fall.live_count", 32'(count), 32'd4);
    chk("fall.live_aidx", 32'(alloc_idx), 32'd2);
    apply(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 5'd0);
    chk("fall.count", 32'(count), 32'd0);
    chk("fall.empty", 32'(empty), 32'd1);
    chk("fall.tail_idx", 32'(tail_idx), 32'd31);
    chk("fall.alloc_idx", 32'(alloc_idx), 32'd31);

    // Reset right behind an accepted allocation
    do_alloc(31'h4242);
    do_reset();
    chk("rst.wen0", 32'(wen0), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.alloc_idx", 32'(alloc_idx), 32'd0);
    chk("rst.tail_idx", 32'(tail_idx), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      bit         r, av, pv, fv, flv, fall;
      logic [4:0] fidx;
      int         n, k;
      r    = ($urandom_range(0, 199) != 0);
      av   = ($urandom_range(0, 9) < 6);
      pv   = ($urandom_range(0, 9) < 2);
      fv   = ($urandom_range(0, 9) < 4);
      flv  = ($urandom_range(0, 99) < 7);
      fall = ($urandom_range(0, 2) == 0);
      fidx = 5'($urandom);
      n    = live.size();
      if (flv && !fall) begin
        if (n == 0 || (fv && n == 1)) begin
          fall = 1'b1;
        end else begin
          k    = int'($urandom_range(fv ? 1 : 0, n - 1));
          fidx = 5'(live[k]);
        end
      end
      apply(r, av, 31'($urandom), pv, 5'($urandom), 31'($urandom), fv, flv, fall, fidx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
